// File: rtl/ac_pkg.sv
// Shared definitions for the Aho-Corasick match reporting path.
//   STATE_W / NPAT / ID_W / POS_W : default widths of automaton state,
//                                   pattern mask, pattern index, position
//   match_rpt_t                   : one serialised report {id, pos}
//   fifo_entry_t                  : one buffered hit {mask, pos}
//   ser_state_t                   : serialiser states
package ac_pkg;

    localparam int STATE_W = 8;
    localparam int NPAT    = 8;
    localparam int ID_W    = 3;
    localparam int POS_W   = 16;

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [POS_W-1:0] pos;
    } match_rpt_t;

    typedef struct packed {
        logic [NPAT-1:0]  mask;
        logic [POS_W-1:0] pos;
    } fifo_entry_t;

    typedef enum logic {
        SER_IDLE = 1'b0,
        SER_EMIT = 1'b1
    } ser_state_t;

endpackage

// File: rtl/match_fifo.sv
// Synchronous show-ahead FIFO holding pending hit entries.
//   clk, rst         : clock, asynchronous active-high reset
//   flush            : synchronous clear of all entries
//   wr_en, wr_data   : push request and data
//   rd_en            : pop request (rd_data is the current head)
//   full, empty      : occupancy flags
// A push while full is accepted when a pop happens in the same cycle.
module match_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr && !flush) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/match_reporter.sv
// Looks up the output function of each automaton state reached by the
// table reader, tags hits with the stream position, buffers them and
// serialises one {pattern id, end position} report per matched pattern.
//   CLK, RST                  : clock, asynchronous active-high reset
//   EN                        : a character step completed this cycle
//   INITIALIZE                : synchronous stream restart (beats EN)
//   NOW_STATE, EN_MATCH       : next state and goto-success from reader
//   MATCH_READY               : consumer accepts the current report
//   MATCH_VALID/ID/POS        : report handshake and payload
//   OVERFLOW                  : sticky, a hit was dropped on a full FIFO
//   BUSY                      : work in flight anywhere in the stage
//
// Serialiser states:
//   state    | meaning
//   SER_IDLE | no report held; pops the FIFO head when one appears
//   SER_EMIT | cur_mask non-zero, reporting its lowest set bit
//
// The output-function ROM is supplied as a packed parameter (state i at
// bits [i*NPAT +: NPAT]) so the contents are fixed at elaboration from the
// generated output-state table without an initialisation block.
module match_reporter
    import ac_pkg::*;
#(
    parameter int STATE_W    = ac_pkg::STATE_W,
    parameter int NUM_STATES = 32,
    parameter int NPAT       = ac_pkg::NPAT,
    parameter int ID_W       = ac_pkg::ID_W,
    parameter int POS_W      = ac_pkg::POS_W,
    parameter int FIFO_DEPTH = 8,
    parameter logic [NUM_STATES*NPAT-1:0] ROM_INIT = '0
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               EN,
    input  logic               INITIALIZE,
    input  logic [STATE_W-1:0] NOW_STATE,
    input  logic               EN_MATCH,
    input  logic               MATCH_READY,
    output logic               MATCH_VALID,
    output logic [ID_W-1:0]    MATCH_ID,
    output logic [POS_W-1:0]   MATCH_POS,
    output logic               OVERFLOW,
    output logic               BUSY
);

    localparam int ROM_AW = $clog2(NUM_STATES);
    localparam logic [STATE_W:0] STATE_LIMIT = (STATE_W+1)'(NUM_STATES);

    typedef struct packed {
        logic [NPAT-1:0]  mask;
        logic [POS_W-1:0] pos;
    } hit_entry_t;

    logic [POS_W-1:0]   pos_q;
    logic               s1_valid;
    logic [STATE_W-1:0] s1_state;
    logic [POS_W-1:0]   s1_pos;
    logic               s1_hit;

    logic [ROM_AW-1:0]  rom_idx;
    logic [NPAT-1:0]    rom_word;
    logic               in_range;
    logic               push_req;

    hit_entry_t         push_entry;
    hit_entry_t         head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_wr;
    logic               pop;

    ser_state_t         state_q, state_n;
    logic [NPAT-1:0]    cur_mask, mask_n;
    logic [POS_W-1:0]   cur_pos, pos_n;
    logic [NPAT-1:0]    rem_mask;
    logic [ID_W-1:0]    low_id;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pos_q    <= '0;
            s1_valid <= 1'b0;
            s1_state <= '0;
            s1_pos   <= '0;
            s1_hit   <= 1'b0;
        end else if (INITIALIZE) begin
            pos_q    <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= EN;
            if (EN) begin
                pos_q    <= pos_q + 1'b1;
                s1_state <= NOW_STATE;
                s1_pos   <= pos_q;
                s1_hit   <= EN_MATCH;
            end
        end
    end

    // Stage 2: output-function lookup; states past the ROM have no output.
    assign rom_idx  = s1_state[ROM_AW-1:0];
    assign rom_word = ROM_INIT[int'(rom_idx)*NPAT +: NPAT];
    assign in_range = ({1'b0, s1_state} < STATE_LIMIT);
    assign push_req = s1_valid && s1_hit && in_range && (rom_word != '0)
                      && !INITIALIZE;

    assign push_entry.mask = rom_word;
    assign push_entry.pos  = s1_pos;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign fifo_wr = push_req && (!fifo_full || pop);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            OVERFLOW <= 1'b0;
        end else if (INITIALIZE) begin
            OVERFLOW <= 1'b0;
        end else if (push_req && fifo_full && !pop) begin
            OVERFLOW <= 1'b1;
        end
    end

    match_fifo #(
        .WIDTH ($bits(hit_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RST),
        .flush   (INITIALIZE),
        .wr_en   (fifo_wr),
        .wr_data (push_entry),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        low_id = '0;
        for (int i = NPAT - 1; i >= 0; i--) begin
            if (cur_mask[i]) low_id = ID_W'(i);
        end
    end

    // Clearing the lowest set bit is exactly mask & (mask - 1).
    assign rem_mask = cur_mask & (cur_mask - 1'b1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= SER_IDLE;
            cur_mask <= '0;
            cur_pos  <= '0;
        end else begin
            state_q  <= state_n;
            cur_mask <= mask_n;
            cur_pos  <= pos_n;
        end
    end

    always_comb begin
        state_n = state_q;
        mask_n  = cur_mask;
        pos_n   = cur_pos;
        pop     = 1'b0;
        unique case (state_q)
            SER_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    mask_n  = head.mask;
                    pos_n   = head.pos;
                    state_n = SER_EMIT;
                end
            end
            SER_EMIT: begin
                if (MATCH_READY) begin
                    if (rem_mask != '0) begin
                        mask_n = rem_mask;
                    end else if (!fifo_empty) begin
                        pop    = 1'b1;
                        mask_n = head.mask;
                        pos_n  = head.pos;
                    end else begin
                        mask_n  = '0;
                        pos_n   = '0;
                        state_n = SER_IDLE;
                    end
                end
            end
            default: state_n = SER_IDLE;
        endcase
        if (INITIALIZE) begin
            state_n = SER_IDLE;
            mask_n  = '0;
            pos_n   = '0;
            pop     = 1'b0;
        end
    end

    assign MATCH_VALID = (state_q == SER_EMIT);
    assign MATCH_ID    = MATCH_VALID ? low_id  : '0;
    assign MATCH_POS   = MATCH_VALID ? cur_pos : '0;
    assign BUSY        = s1_valid || !fifo_empty || MATCH_VALID;

endmodule

// File: tb/tb_match_reporter.sv
// Directed bench for match_reporter with a small hand-written ROM
// (state 2 -> 0x01, state 5 -> 0x06) and a 4-bit position counter.
module tb_match_reporter;

    localparam int STATE_W    = 8;
    localparam int NUM_STATES = 32;
    localparam int NPAT       = 8;
    localparam int ID_W       = 3;
    localparam int POS_W      = 4;
    localparam int FIFO_DEPTH = 8;
    localparam logic [NUM_STATES*NPAT-1:0] TB_ROM =
        (256'h06 << 40) | (256'h01 << 16);

    logic               CLK;
    logic               RST;
    logic               EN;
    logic               INITIALIZE;
    logic [STATE_W-1:0] NOW_STATE;
    logic               EN_MATCH;
    logic               MATCH_READY;
    logic               MATCH_VALID;
    logic [ID_W-1:0]    MATCH_ID;
    logic [POS_W-1:0]   MATCH_POS;
    logic               OVERFLOW;
    logic               BUSY;

    int checks = 0;
    int errors = 0;

    match_reporter #(
        .STATE_W    (STATE_W),
        .NUM_STATES (NUM_STATES),
        .NPAT       (NPAT),
        .ID_W       (ID_W),
        .POS_W      (POS_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .ROM_INIT   (TB_ROM)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .EN          (EN),
        .INITIALIZE  (INITIALIZE),
        .NOW_STATE   (NOW_STATE),
        .EN_MATCH    (EN_MATCH),
        .MATCH_READY (MATCH_READY),
        .MATCH_VALID (MATCH_VALID),
        .MATCH_ID    (MATCH_ID),
        .MATCH_POS   (MATCH_POS),
        .OVERFLOW    (OVERFLOW),
        .BUSY        (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic en, input logic [STATE_W-1:0] st,
                         input logic hit);
        EN        = en;
        NOW_STATE = st;
        EN_MATCH  = hit;
    endtask

    initial begin
        RST         = 1'b1;
        EN          = 1'b0;
        INITIALIZE  = 1'b0;
        NOW_STATE   = '0;
        EN_MATCH    = 1'b0;
        MATCH_READY = 1'b1;

        repeat (2) tick();
        check_val("rst_valid", 32'(MATCH_VALID), 0);
        check_val("rst_id",    32'(MATCH_ID),    0);
        check_val("rst_pos",   32'(MATCH_POS),   0);
        check_val("rst_ovf",   32'(OVERFLOW),    0);
        check_val("rst_busy",  32'(BUSY),        0);
        RST = 1'b0;

        // Single hit on the 4th character
        drive(1'b1, 8'd0, 1'b0);
        repeat (3) tick();
        drive(1'b1, 8'd2, 1'b1);
        tick();
        drive(1'b0, 8'd0, 1'b0);
        check_val("single_v_n0", 32'(MATCH_VALID), 0);
        check_val("single_busy", 32'(BUSY), 1);
        tick();
        check_val("single_v_n1", 32'(MATCH_VALID), 0);
        tick();
        check_val("single_v_n2", 32'(MATCH_VALID), 1);
        check_val("single_id",   32'(MATCH_ID),    0);
        check_val("single_pos",  32'(MATCH_POS),   3);
        tick();
        check_val("single_v_n3", 32'(MATCH_VALID), 0);

        // Multi-pattern state at position 0
        INITIALIZE = 1'b1;
        tick();
        INITIALIZE = 1'b0;
        drive(1'b1, 8'd5, 1'b1);
        tick();
        drive(1'b0, 8'd0, 1'b0);
        tick();
        tick();
        check_val("multi_v0",   32'(MATCH_VALID), 1);
        check_val("multi_id0",  32'(MATCH_ID),    1);
        check_val("multi_pos0", 32'(MATCH_POS),   0);
        tick();
        check_val("multi_v1",   32'(MATCH_VALID), 1);
        check_val("multi_id1",  32'(MATCH_ID),    2);
        check_val("multi_pos1", 32'(MATCH_POS),   0);
        tick();
        check_val("multi_v_end", 32'(MATCH_VALID), 0);

        // EN_MATCH gating (pos 1) and out-of-range state 37 (pos 2)
        drive(1'b1, 8'd5, 1'b0);
        tick();
        drive(1'b1, 8'd37, 1'b1);
        tick();
        drive(1'b0, 8'd0, 1'b0);
        repeat (3) tick();
        check_val("gate_valid", 32'(MATCH_VALID), 0);
        check_val("gate_busy",  32'(BUSY),        0);
        drive(1'b1, 8'd2, 1'b1);
        tick();
        drive(1'b0, 8'd0, 1'b0);
        tick();
        tick();
        check_val("gate_hit_v",   32'(MATCH_VALID), 1);
        check_val("gate_hit_pos", 32'(MATCH_POS),   3);
        tick();

        // Back-pressure: 1 in serialiser + 8 in FIFO, then overflow
        INITIALIZE = 1'b1;
        tick();
        INITIALIZE  = 1'b0;
        MATCH_READY = 1'b0;
        drive(1'b1, 8'd2, 1'b1);
        repeat (9) tick();
        drive(1'b0, 8'd0, 1'b0);
        tick();
        tick();
        check_val("bp_ovf0",  32'(OVERFLOW),    0);
        check_val("bp_valid", 32'(MATCH_VALID), 1);
        check_val("bp_pos",   32'(MATCH_POS),   0);
        check_val("bp_busy",  32'(BUSY),        1);
        drive(1'b1, 8'd2, 1'b1);
        tick();
        drive(1'b0, 8'd0, 1'b0);
        tick();
        check_val("bp_ovf1",      32'(OVERFLOW),    1);
        check_val("bp_hold_v",    32'(MATCH_VALID), 1);
        check_val("bp_hold_id",   32'(MATCH_ID),    0);
        check_val("bp_hold_pos",  32'(MATCH_POS),   0);
        MATCH_READY = 1'b1;
        for (int i = 0; i < 9; i++) begin
            check_val($sformatf("bp_drain_v%0d", i),   32'(MATCH_VALID), 1);
            check_val($sformatf("bp_drain_pos%0d", i), 32'(MATCH_POS), 32'(i));
            tick();
        end
        check_val("bp_drain_end", 32'(MATCH_VALID), 0);
        check_val("bp_ovf_stick", 32'(OVERFLOW),    1);

        // INITIALIZE with 3 reports pending and EN high
        MATCH_READY = 1'b0;
        drive(1'b1, 8'd2, 1'b1);
        repeat (3) tick();
        drive(1'b0, 8'd0, 1'b0);
        tick();
        tick();
        check_val("init_pre_v",   32'(MATCH_VALID), 1);
        check_val("init_pre_pos", 32'(MATCH_POS),   10);
        check_val("init_pre_ovf", 32'(OVERFLOW),    1);
        INITIALIZE = 1'b1;
        drive(1'b1, 8'd2, 1'b1);
        tick();
        INITIALIZE = 1'b0;
        drive(1'b0, 8'd0, 1'b0);
        check_val("init_valid", 32'(MATCH_VALID), 0);
        check_val("init_ovf",   32'(OVERFLOW),    0);
        check_val("init_busy",  32'(BUSY),        0);
        MATCH_READY = 1'b1;
        drive(1'b1, 8'd2, 1'b1);
        tick();
        drive(1'b0, 8'd0, 1'b0);
        tick();
        tick();
        check_val("init_next_v",   32'(MATCH_VALID), 1);
        check_val("init_next_pos", 32'(MATCH_POS),   0);
        tick();

        // Position wrap: hit on the 17th character
        INITIALIZE = 1'b1;
        tick();
        INITIALIZE = 1'b0;
        drive(1'b1, 8'd0, 1'b0);
        repeat (16) tick();
        drive(1'b1, 8'd2, 1'b1);
        tick();
        drive(1'b0, 8'd0, 1'b0);
        tick();
        tick();
        check_val("wrap_v",   32'(MATCH_VALID), 1);
        check_val("wrap_id",  32'(MATCH_ID),    0);
        check_val("wrap_pos", 32'(MATCH_POS),   0);
        tick();
        check_val("wrap_end", 32'(MATCH_VALID), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
